field_buffer: RTL and testbench

- Double-buffered, writable cell-field memory for the Game-of-Life datapath.
- Holds a front bank, which the display and neighbour logic read, and a back bank, which the next-generation update logic writes.
- i_swap exchanges the two banks at a generation boundary.
- On reset or i_reload, a sequencer loads a built-in start pattern, selected by CONFIG_ID, into the front bank one cell per clock.

---
 rtl/field_buffer_if.sv | 49 ++++
 rtl/field_buffer.sv | 158 +++++++++++++++
 tb/tb_field_buffer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/field_buffer_if.sv
// Request/response bundle for the double-buffered cell field.
//
// Handshake: i_rd_en, i_wr_en, i_swap and i_reload are single-cycle
// requests. The field accepts a read, write or swap only while o_ready
// is 1 and drops it silently otherwise; there is no other backpressure.
// Every accepted read answers with o_rd_valid=1 exactly one cycle later,
// carrying the cell value on o_rd_state. i_reload is accepted at any time.
//
// Signals:
//   i_reload              restart the start-pattern load
//   i_swap                exchange front and back banks
//   i_rd_en/i_rd_x/i_rd_y read request on the front bank
//   o_rd_state/o_rd_valid registered read response
//   i_wr_en/i_wr_x/i_wr_y/i_wr_state  write request on the back bank
//   o_ready               field loaded
//   o_gen_cnt             swaps since the last load
//   o_dbg_state           sequencer state (0 = LOAD, 1 = READY)
interface field_buffer_if #(
  parameter int X_ADR_SIZE = 2,
  parameter int Y_ADR_SIZE = 2,
  parameter int GEN_W      = 8
);
  logic                  i_reload;
  logic                  i_swap;
  logic                  i_rd_en;
  logic [X_ADR_SIZE-1:0] i_rd_x;
  logic [Y_ADR_SIZE-1:0] i_rd_y;
  logic                  o_rd_state;
  logic                  o_rd_valid;
  logic                  i_wr_en;
  logic [X_ADR_SIZE-1:0] i_wr_x;
  logic [Y_ADR_SIZE-1:0] i_wr_y;
  logic                  i_wr_state;
  logic                  o_ready;
  logic [GEN_W-1:0]      o_gen_cnt;
  logic                  o_dbg_state;

  modport master (
    output i_reload, i_swap, i_rd_en, i_rd_x, i_rd_y,
           i_wr_en, i_wr_x, i_wr_y, i_wr_state,
    input  o_rd_state, o_rd_valid, o_ready, o_gen_cnt, o_dbg_state
  );

  modport slave (
    input  i_reload, i_swap, i_rd_en, i_rd_x, i_rd_y,
           i_wr_en, i_wr_x, i_wr_y, i_wr_state,
    output o_rd_state, o_rd_valid, o_ready, o_gen_cnt, o_dbg_state
  );
endinterface

// File: rtl/field_buffer.sv
// Double-buffered Game-of-Life cell field.
//
// The front bank is read by display/neighbour logic, the back bank is
// written by the next-generation logic, and i_swap exchanges them. After
// reset or i_reload a sequencer writes the CONFIG_ID start pattern into
// the front bank, one cell per clock in raster order (x fastest); o_ready
// rises when the last cell has been written.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      field_buffer_if slave modport (requests, read data, status)
module field_buffer #(
  parameter int FIELD_W   = 4,
  parameter int FIELD_H   = 3,
  parameter int CONFIG_ID = 1,
  parameter int GEN_W     = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  field_buffer_if.slave  bus
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  localparam int N          = FIELD_W * FIELD_H;
  localparam int IDX_W      = $clog2(N);

  typedef enum logic {LOAD = 1'b0, READY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [X_ADR_SIZE-1:0] ld_x_q, ld_x_d;
  logic [Y_ADR_SIZE-1:0] ld_y_q, ld_y_d;
  logic                  front_q, front_d;
  logic [GEN_W-1:0]      gen_q, gen_d;
  logic                  rd_state_q, rd_state_d;
  logic                  rd_valid_q, rd_valid_d;
  // bank_q[b][k] is cell k = y*FIELD_W + x of bank b; front_q names the front bank.
  logic [1:0][N-1:0]     bank_q, bank_d;

  logic [IDX_W-1:0]      ld_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  ld_last_x;
  logic                  ld_last_y;

  // Start pattern; the scan only visits in-field cells, so pattern cells
  // outside a small field are never written.
  function automatic logic pattern(input int x, input int y);
    logic alive;
    alive = 1'b0;
    case (CONFIG_ID)
      0:       alive = 1'b0;
      1:       alive = (y == 1) && (x <= 2);
      2:       alive = ((x == 1) && (y == 0)) || ((x == 2) && (y == 1)) ||
                       ((y == 2) && (x <= 2));
      default: alive = (((x + y) % 2) == 0);
    endcase
    return alive;
  endfunction

  // Linear indices are only used when the address is in range, so the
  // truncation of an out-of-range index is harmless.
  assign ld_idx = IDX_W'(int'(ld_y_q) * FIELD_W + int'(ld_x_q));
  assign rd_idx = IDX_W'(int'(bus.i_rd_y) * FIELD_W + int'(bus.i_rd_x));
  assign wr_idx = IDX_W'(int'(bus.i_wr_y) * FIELD_W + int'(bus.i_wr_x));

  assign rd_in_range = (int'(bus.i_rd_x) < FIELD_W) && (int'(bus.i_rd_y) < FIELD_H);
  assign wr_in_range = (int'(bus.i_wr_x) < FIELD_W) && (int'(bus.i_wr_y) < FIELD_H);

  assign ld_last_x = (ld_x_q == X_ADR_SIZE'(FIELD_W - 1));
  assign ld_last_y = (ld_y_q == Y_ADR_SIZE'(FIELD_H - 1));

  always_comb begin
    state_d    = state_q;
    ld_x_d     = ld_x_q;
    ld_y_d     = ld_y_q;
    front_d    = front_q;
    gen_d      = gen_q;
    rd_state_d = rd_state_q;
    rd_valid_d = 1'b0;
    bank_d     = bank_q;

    if (bus.i_reload) begin
      // Reload wins over everything; a pending write or swap is dropped.
      state_d = LOAD;
      ld_x_d  = '0;
      ld_y_d  = '0;
      front_d = 1'b0;
      gen_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          // front_q is always 0 while loading, so bank 0 is the front bank.
          bank_d[0][ld_idx] = pattern(int'(ld_x_q), int'(ld_y_q));
          if (ld_last_x) begin
            ld_x_d = '0;
            if (ld_last_y) begin
              ld_y_d  = '0;
              state_d = READY;
            end else begin
              ld_y_d = ld_y_q + Y_ADR_SIZE'(1);
            end
          end else begin
            ld_x_d = ld_x_q + X_ADR_SIZE'(1);
          end
        end
        READY: begin
          // Read and write use the pre-swap bank select, so a same-cycle
          // write lands in the bank that becomes front after the swap.
          if (bus.i_rd_en) begin
            rd_valid_d = 1'b1;
            rd_state_d = rd_in_range ? bank_q[front_q][rd_idx] : 1'b0;
          end
          if (bus.i_wr_en && wr_in_range) begin
            bank_d[~front_q][wr_idx] = bus.i_wr_state;
          end
          if (bus.i_swap) begin
            front_d = ~front_q;
            gen_d   = gen_q + GEN_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= LOAD;
      ld_x_q     <= '0;
      ld_y_q     <= '0;
      front_q    <= 1'b0;
      gen_q      <= '0;
      rd_state_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_x_q     <= ld_x_d;
      ld_y_q     <= ld_y_d;
      front_q    <= front_d;
      gen_q      <= gen_d;
      rd_state_q <= rd_state_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Cell storage has no reset: contents are rebuilt by the load sequencer.
  always_ff @(posedge i_clk) begin
    bank_q <= bank_d;
  end

  assign bus.o_rd_state  = rd_state_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_ready     = (state_q == READY);
  assign bus.o_gen_cnt   = gen_q;
  assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_field_buffer.sv
// Bench for field_buffer: two instances (blinker with an 8-bit generation
// counter, glider with a 2-bit counter) share one stimulus stream and are
// compared every cycle against a per-instance behavioural model.
module tb_field_buffer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int XW = 2;
  localparam int YW = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       rd_en = 1'b0, wr_en = 1'b0, wr_state = 1'b0, swap = 1'b0, reload = 1'b0;
  logic [1:0] rd_x = '0, rd_y = '0, wr_x = '0, wr_y = '0;

  field_buffer_if #(.X_ADR_SIZE(XW), .Y_ADR_SIZE(YW), .GEN_W(8)) if_a ();
  field_buffer_if #(.X_ADR_SIZE(XW), .Y_ADR_SIZE(YW), .GEN_W(2)) if_b ();

  assign if_a.i_reload = reload;  assign if_b.i_reload = reload;
  assign if_a.i_swap = swap;      assign if_b.i_swap = swap;
  assign if_a.i_rd_en = rd_en;    assign if_b.i_rd_en = rd_en;
  assign if_a.i_rd_x = rd_x;      assign if_b.i_rd_x = rd_x;
  assign if_a.i_rd_y = rd_y;      assign if_b.i_rd_y = rd_y;
  assign if_a.i_wr_en = wr_en;    assign if_b.i_wr_en = wr_en;
  assign if_a.i_wr_x = wr_x;      assign if_b.i_wr_x = wr_x;
  assign if_a.i_wr_y = wr_y;      assign if_b.i_wr_y = wr_y;
  assign if_a.i_wr_state = wr_state; assign if_b.i_wr_state = wr_state;

  field_buffer #(.FIELD_W(W), .FIELD_H(H), .CONFIG_ID(1), .GEN_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
  field_buffer #(.FIELD_W(W), .FIELD_H(H), .CONFIG_ID(2), .GEN_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));

  logic       o_ready[2], o_valid[2], o_state[2];
  logic [7:0] o_gen[2];
  assign o_ready[0] = if_a.o_ready;    assign o_ready[1] = if_b.o_ready;
  assign o_valid[0] = if_a.o_rd_valid; assign o_valid[1] = if_b.o_rd_valid;
  assign o_state[0] = if_a.o_rd_state; assign o_state[1] = if_b.o_rd_state;
  assign o_gen[0]   = if_a.o_gen_cnt;  assign o_gen[1]   = {6'b0, if_b.o_gen_cnt};

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int cfg[2]   = '{1, 2};
  int gmask[2] = '{255, 3};
  bit mval[2][2][N];   // [instance][bank][cell]
  bit mknw[2][2][N];   // cell content known (back bank is undefined after power-up)
  bit m_ready[2];
  int m_left[2];       // load cycles still to go
  int m_gen[2];
  bit m_front[2];
  bit m_valid[2];
  bit m_rd[2];
  bit m_rdk[2];

  function automatic bit pat(int c, int x, int y);
    case (c)
      0: return 1'b0;
      1: return (y == 1) && (x <= 2);
      2: return (x == 1 && y == 0) || (x == 2 && y == 1) || (y == 2 && x <= 2);
      default: return ((x + y) % 2) == 0;
    endcase
  endfunction

  function automatic void model_load(int d);
    m_ready[d] = 1'b0;
    m_left[d]  = N;
    m_gen[d]   = 0;
    m_front[d] = 1'b0;
    m_valid[d] = 1'b0;
    for (int i = 0; i < N; i++) begin
      mval[d][0][i] = pat(cfg[d], i % W, i / W);
      mknw[d][0][i] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      model_load(d);
      m_rd[d]  = 1'b0;
      m_rdk[d] = 1'b1;
    end
  endfunction

  // One clock edge of the model, using the inputs held across that edge.
  function automatic void model_step();
    int ri, wi;
    if (!rst_n) return;
    ri = int'(rd_y) * W + int'(rd_x);
    wi = int'(wr_y) * W + int'(wr_x);
    for (int d = 0; d < 2; d++) begin
      if (reload) begin
        model_load(d);
      end else if (!m_ready[d]) begin
        if (m_left[d] == 1) m_ready[d] = 1'b1;
        m_left[d]--;
      end else begin
        m_valid[d] = rd_en;
        if (rd_en) begin
          if (int'(rd_x) < W && int'(rd_y) < H) begin
            m_rd[d]  = mval[d][m_front[d]][ri];
            m_rdk[d] = mknw[d][m_front[d]][ri];
          end else begin
            m_rd[d]  = 1'b0;
            m_rdk[d] = 1'b1;
          end
        end
        if (wr_en && int'(wr_x) < W && int'(wr_y) < H) begin
          mval[d][!m_front[d]][wi] = wr_state;
          mknw[d][!m_front[d]][wi] = 1'b1;
        end
        if (swap) begin
          m_front[d] = !m_front[d];
          m_gen[d]   = (m_gen[d] + 1) & gmask[d];
        end
      end
    end
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready[%0d]", d), int'(o_ready[d]), int'(m_ready[d]));
        chk($sformatf("gen_cnt[%0d]", d), int'(o_gen[d]), m_gen[d]);
        chk($sformatf("rd_valid[%0d]", d), int'(o_valid[d]), int'(m_valid[d]));
        if (m_valid[d] && m_rdk[d])
          chk($sformatf("rd_state[%0d]", d), int'(o_state[d]), int'(m_rd[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit re, input int rx, input int ry,
                      input bit we, input int wx, input int wy, input bit ws,
                      input bit sw, input bit rl);
    @(posedge clk);
    model_step();
    #1;
    rd_en = re; rd_x = 2'(rx); rd_y = 2'(ry);
    wr_en = we; wr_x = 2'(wx); wr_y = 2'(wy); wr_state = ws;
    swap = sw; reload = rl;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Issue one read and leave the response on the outputs.
  task automatic rd_cell(input int x, input int y);
    step(1, x, y, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic assert_reset();
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b1;
  endtask

  // o_ready must stay low for exactly N cycles, then rise.
  task automatic wait_load(input string tag);
    for (int i = 1; i <= N; i++) begin
      idle();
      chk($sformatf("%s_ready_a_c%0d", tag, i), int'(o_ready[0]), (i == N) ? 1 : 0);
      chk($sformatf("%s_ready_b_c%0d", tag, i), int'(o_ready[1]), (i == N) ? 1 : 0);
    end
  endtask

  string rows_a[3] = '{"0000", "1110", "0000"};
  string rows_b[3] = '{"0100", "0010", "1110"};

  task automatic raster(input string tag);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        rd_cell(x, y);
        chk($sformatf("%s_a_%0d_%0d", tag, x, y), int'(o_state[0]), (rows_a[y][x] == "1") ? 1 : 0);
        chk($sformatf("%s_b_%0d_%0d", tag, x, y), int'(o_state[1]), (rows_b[y][x] == "1") ? 1 : 0);
        chk($sformatf("%s_valid_%0d_%0d", tag, x, y), int'(o_valid[0]), 1);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    rst_n = 1'b0;
    model_reset();
    chk_on = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready[%0d]", d), int'(o_ready[d]), 0);
      chk($sformatf("rst_valid[%0d]", d), int'(o_valid[d]), 0);
      chk($sformatf("rst_state[%0d]", d), int'(o_state[d]), 0);
      chk($sformatf("rst_gen[%0d]", d), int'(o_gen[d]), 0);
    end
    idle();
    idle();
    release_reset();
    wait_load("load");
    raster("init");

    // Dead border: row 3 is outside a 3-row field.
    rd_cell(1, 3);
    chk("border_state", int'(o_state[0]), 0);
    chk("border_valid", int'(o_valid[0]), 1);

    // Double buffer: back-bank write is invisible until the swap.
    step(0, 0, 0, 1, 0, 0, 1, 0, 0);
    rd_cell(0, 0);
    chk("dbuf_pre_a", int'(o_state[0]), 0);
    chk("dbuf_pre_b", int'(o_state[1]), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rd_cell(0, 0);
    chk("dbuf_post_a", int'(o_state[0]), 1);
    chk("dbuf_post_b", int'(o_state[1]), 1);
    chk("dbuf_gen_a", int'(o_gen[0]), 1);
    rd_cell(1, 1);

    // Out-of-range write is dropped, even after a swap exposes that bank.
    step(0, 0, 0, 1, 1, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rd_cell(1, 3);
    chk("border_wr_a", int'(o_state[0]), 0);
    chk("border_wr_b", int'(o_state[1]), 0);

    // Same cycle: write (3,2)=1, swap, read (0,1) from the pre-swap front.
    step(1, 0, 1, 1, 3, 2, 1, 1, 0);
    idle();
    chk("same_rd_a", int'(o_state[0]), 1);
    chk("same_rd_b", int'(o_state[1]), 0);
    rd_cell(3, 2);
    chk("same_wr_a", int'(o_state[0]), 1);
    chk("same_wr_b", int'(o_state[1]), 1);
    chk("gen3_a", int'(o_gen[0]), 3);
    chk("gen3_b", int'(o_gen[1]), 3);

    // 2-bit counter wraps on its fourth swap.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("wrap_b", int'(o_gen[1]), 0);
    chk("nowrap_a", int'(o_gen[0]), 4);

    // Three swaps, then reload together with a swap: reload wins.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("pre_reload_gen_b", int'(o_gen[1]), 3);
    step(0, 0, 0, 1, 0, 1, 1, 1, 1);
    idle();
    chk("reload_gen_a", int'(o_gen[0]), 0);
    chk("reload_gen_b", int'(o_gen[1]), 0);
    chk("reload_ready_a", int'(o_ready[0]), 0);
    wait_load("reload");
    raster("reloaded");

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit re, we, ws, sw, rl;
      rl = ($urandom_range(0, 299) == 0);
      re = rl ? 1'b0 : 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ws = 1'($urandom_range(0, 1));
      sw = ($urandom_range(0, 7) == 0);
      step(re, $urandom_range(0, 3), $urandom_range(0, 3),
           we, $urandom_range(0, 3), $urandom_range(0, 3), ws, sw, rl);
    end
    idle();

    // Reset in the middle of a load.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 5; i++) idle();
    assert_reset();
    #1;
    chk("midload_ready_a", int'(o_ready[0]), 0);
    chk("midload_ready_b", int'(o_ready[1]), 0);
    chk("midload_gen_a", int'(o_gen[0]), 0);
    idle();
    release_reset();
    wait_load("midload");
    raster("midload");

    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
